// File: rtl/hazard_sched.sv
// hazard_sched: pipeline hazard scheduler for the 16-bit 5-stage core.
// It controls the PC and IF/ID write enables, injects ID/EX bubbles and
// flushes IF/ID. Three stall sources are arbitrated in this priority order:
// data-memory wait, then taken-branch flush, then load-use.
// Optional feature macro: HAZARD_SCHED_PERF_EN adds the stall_cnt and
// flush_cnt saturating performance counters.
module hazard_sched #(
  parameter int FLUSH_CYC   = 2,   // 1..7
  parameter int MEMWAIT_MAX = 15   // 1..255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] id_instr,
  input  logic        ex_memread,
  input  logic [2:0]  ex_rt,
  input  logic        br_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        pipe_freeze,
  output logic        mem_timeout
`ifdef HAZARD_SCHED_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_MEM_WAIT} state_t;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYC - 1);
  localparam logic [8:0] WAIT_LIMIT = 9'(MEMWAIT_MAX);

  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_pend_br;
  logic [7:0] r_wait;    // wait cycles already spent in the current memory stall

  logic [2:0] w_op;
  logic [2:0] w_rs;
  logic [2:0] w_rt;
  logic       w_rt_used;
  logic       w_load_use;
  logic       w_mem_stall;
  logic       w_waiting;
  logic [8:0] w_wait_idx;

  assign w_op  = id_instr[15:13];
  assign w_rs  = id_instr[12:10];
  assign w_rt  = id_instr[9:7];

  // rt is a source operand only for R-type, BEQ and SW
  assign w_rt_used  = (w_op == 3'd0) || (w_op == 3'd2) || (w_op == 3'd6);
  assign w_load_use = ex_memread && (ex_rt != 3'd0) && (id_instr != 16'h0000) &&
                      ((ex_rt == w_rs) || ((ex_rt == w_rt) && w_rt_used));

  assign w_mem_stall = mem_req && !mem_ready;

  // Once in MEM_WAIT the access is outstanding, so only mem_ready releases it.
  assign w_waiting  = (r_state == ST_MEM_WAIT) ? !mem_ready : w_mem_stall;

  // 1-based index of the current wait cycle; saturates past 255 so the
  // timeout pulse can never repeat within one stall.
  assign w_wait_idx = (r_state == ST_MEM_WAIT) ? ({1'b0, r_wait} + 9'd1) : 9'd1;

  // Combinational output decode from state and inputs, in priority order
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    pipe_freeze = 1'b0;
    mem_timeout = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
    end else if (w_waiting) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
      mem_timeout = (w_wait_idx == WAIT_LIMIT);
    end else if ((r_state == ST_FLUSH) || ((r_state == ST_RUN) && br_taken)) begin
      // IF/ID loads zero and the branch target loads into the PC
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if ((r_state == ST_RUN) && w_load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // State, flush counter, pending-branch flag and wait counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_cnt     <= 3'd0;
      r_pend_br <= 1'b0;
      r_wait    <= 8'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            r_state   <= ST_MEM_WAIT;
            r_cnt     <= 3'd1;
            r_pend_br <= br_taken;
            r_wait    <= 8'd1;
          end else if (br_taken && (FLUSH_CYC > 1)) begin
            r_state <= ST_FLUSH;
            r_cnt   <= 3'd1;
          end
        end
        ST_FLUSH: begin
          if (w_mem_stall) begin
            // Unfinished flush resumes from the start once memory is ready
            r_state   <= ST_MEM_WAIT;
            r_cnt     <= 3'd1;
            r_pend_br <= 1'b1;
            r_wait    <= 8'd1;
          end else if (r_cnt == FLUSH_LAST) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            r_state   <= r_pend_br ? ST_FLUSH : ST_RUN;
            r_cnt     <= 3'd0;
            r_pend_br <= 1'b0;
            r_wait    <= 8'd0;
          end else begin
            r_pend_br <= r_pend_br | br_taken;
            if (r_wait != 8'hFF) begin
              r_wait <= r_wait + 8'd1;
            end
          end
        end
        default: begin
          r_state   <= ST_RUN;
          r_cnt     <= 3'd0;
          r_pend_br <= 1'b0;
          r_wait    <= 8'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_SCHED_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // Saturating counters of PC-stall cycles and IF/ID flush cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (!pc_write && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (ifid_flush && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed checks of reset, load-use detection, branch
// flush, memory wait with latched branch and timeout, and mid-operation reset.
// Output vector order: {pc_write, ifid_write, idex_bubble, ifid_flush,
// pipe_freeze, mem_timeout}.
module tb_hazard_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] id_instr;
  logic        ex_memread;
  logic [2:0]  ex_rt;
  logic        br_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        pipe_freeze;
  logic        mem_timeout;
`ifdef HAZARD_SCHED_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] O_RESET  = 6'b001100;
  localparam logic [5:0] O_IDLE   = 6'b110000;
  localparam logic [5:0] O_LDUSE  = 6'b001000;
  localparam logic [5:0] O_FLUSH  = 6'b111100;
  localparam logic [5:0] O_FREEZE = 6'b000010;
  localparam logic [5:0] O_TMO    = 6'b000011;

  logic [5:0] outs;
  assign outs = {pc_write, ifid_write, idex_bubble, ifid_flush, pipe_freeze, mem_timeout};

  always #5 clock = ~clock;

  hazard_sched #(.FLUSH_CYC(2), .MEMWAIT_MAX(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .id_instr   (id_instr),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .br_taken   (br_taken),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ifid_write (ifid_write),
    .idex_bubble(idex_bubble),
    .ifid_flush (ifid_flush),
    .pipe_freeze(pipe_freeze),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_SCHED_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Let combinational outputs settle, then compare
  task automatic chk(input string tag, input logic [5:0] exp);
    #1;
    checks++;
    assert (outs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
    end
    $display("check %s outs=%b exp=%b", tag, outs, exp);
  endtask

  initial begin
    reset = 1'b1; id_instr = 16'h0000; ex_memread = 1'b0; ex_rt = 3'd0;
    br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

    // 1: reset held three cycles, then release
    chk("reset_c0", O_RESET);
    tick(); chk("reset_c1", O_RESET);
    tick(); chk("reset_c2", O_RESET);
    tick(); reset = 1'b0;
    chk("run_idle", O_IDLE);

    // 2: load-use detection
    ex_memread = 1'b1; ex_rt = 3'd3; id_instr = 16'h0D80;   // R rs=3
    chk("lu_r_rs", O_LDUSE);
    tick(); ex_memread = 1'b0;
    chk("lu_cleared", O_IDLE);
    ex_memread = 1'b1; ex_rt = 3'd0;
    chk("lu_rt0", O_IDLE);
    ex_rt = 3'd3; id_instr = 16'hA180;                       // LW rt=3, rt not a source
    chk("lu_lw_rt", O_IDLE);
    id_instr = 16'hC180;                                     // SW rt=3
    chk("lu_sw_rt", O_LDUSE);
    id_instr = 16'h4180;                                     // BEQ rt=3
    chk("lu_beq_rt", O_LDUSE);
    id_instr = 16'hE180;                                     // unknown op, rt unused
    chk("lu_unk_rt", O_IDLE);
    id_instr = 16'h0000;
    chk("lu_nop", O_IDLE);
    ex_memread = 1'b0;

    // 3: taken branch flushes exactly two cycles; load-use ignored in FLUSH
    tick(); br_taken = 1'b1;
    chk("br_c1", O_FLUSH);
    tick(); br_taken = 1'b0;
    ex_memread = 1'b1; ex_rt = 3'd3; id_instr = 16'h0D80;
    chk("br_c2_lu_ignored", O_FLUSH);
    tick(); ex_memread = 1'b0; id_instr = 16'h0000;
    chk("br_done", O_IDLE);

    // 4: memory wait with branch latched on first wait cycle, timeout at 3
    mem_req = 1'b1; mem_ready = 1'b0; br_taken = 1'b1;
    chk("mw_c1", O_FREEZE);
    tick(); br_taken = 1'b0;
    chk("mw_c2", O_FREEZE);
    tick(); chk("mw_c3_timeout", O_TMO);
    tick(); chk("mw_c4", O_FREEZE);
    tick(); mem_ready = 1'b1;
    chk("mw_ready", O_IDLE);
    tick(); mem_req = 1'b0; mem_ready = 1'b0;
    chk("mw_flush1", O_FLUSH);
    tick(); chk("mw_flush2", O_FLUSH);
    tick(); chk("mw_run", O_IDLE);

    // 5: reset in FLUSH with cnt=1
    br_taken = 1'b1;
    chk("rf_br", O_FLUSH);
    tick(); br_taken = 1'b0; reset = 1'b1;
    chk("rf_reset", O_RESET);
    tick(); reset = 1'b0;
    chk("rf_run", O_IDLE);

    // 5b: reset in MEM_WAIT with a pending branch abandons it
    mem_req = 1'b1; br_taken = 1'b1;
    chk("rm_c1", O_FREEZE);
    tick(); br_taken = 1'b0; reset = 1'b1;
    chk("rm_reset", O_RESET);
    tick(); reset = 1'b0; mem_req = 1'b0;
    chk("rm_run", O_IDLE);
    tick(); chk("rm_no_flush", O_IDLE);

`ifdef HAZARD_SCHED_PERF_EN
    // 6: stall counter saturates
    reset = 1'b1;
    tick(); reset = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 70000; i++) tick();
    checks++;
    assert (stall_cnt === 16'hFFFF) else begin
      failures++;
      $error("FAIL perf_stall_sat observed=%h expected=%h", stall_cnt, 16'hFFFF);
    end
    $display("check perf_stall_sat stall_cnt=%h", stall_cnt);
    mem_req = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
